// File: rtl/fp_sqrt_iter_if.sv
// Operand/result bundle for the iterative square-root unit.
// The master drives the operand and start, and the slave returns the result and status.
interface fp_sqrt_iter_if #(
  parameter int unsigned M_SIZE   = 53,
  parameter int unsigned EXP_SIZE = 11
);
  logic [M_SIZE-1:0]   in_mantisa;
  logic [EXP_SIZE-1:0] in_exp;
  logic                in_sign;
  logic [2:0]          in_flags;
  logic [1:0]          rnd_mode;
  logic                start;
  logic [M_SIZE-1:0]   out_mantisa;
  logic [EXP_SIZE-1:0] out_exp;
  logic                out_sign;
  logic [2:0]          out_flags;
  logic                busy;
  logic                ready;

  modport master (
    output in_mantisa, in_exp, in_sign, in_flags, rnd_mode, start,
    input  out_mantisa, out_exp, out_sign, out_flags, busy, ready
  );

  modport slave (
    input  in_mantisa, in_exp, in_sign, in_flags, rnd_mode, start,
    output out_mantisa, out_exp, out_sign, out_flags, busy, ready
  );
endinterface

// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-style square root: restoring recurrence, BPC root bits per cycle,
// subnormal pre-normalisation, four rounding modes and special-value handling.
module fp_sqrt_iter #(
  parameter int unsigned M_SIZE   = 53,
  parameter int unsigned EXP_SIZE = 11,
  parameter int unsigned BPC      = 1
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fp_sqrt_iter_if.slave io_bus
);
  localparam int unsigned N  = (M_SIZE + BPC) / BPC;
  localparam int unsigned NB = N * BPC;
  localparam int unsigned RW = NB + 3;
  localparam int unsigned DW = 2 * NB;
  localparam int unsigned SH = DW - M_SIZE - 1;
  localparam int unsigned EW = EXP_SIZE + 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int BIAS_I = (1 << (EXP_SIZE - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS = EW'(BIAS_I);

  typedef enum logic [2:0] {StIdle, StPrep, StNorm, StIter, StRound, StDone} state_e;

  state_e                r_state, w_state;
  logic                  r_start_q;
  logic [M_SIZE-1:0]     r_mant, w_mant;
  logic signed [EW-1:0]  r_e, w_e;
  logic                  r_sign, w_sign;
  logic [2:0]            r_flags, w_flags;
  logic [1:0]            r_rnd, w_rnd;
  logic [DW-1:0]         r_rad, w_rad;
  logic [RW-1:0]         r_rem, w_rem;
  logic [NB-1:0]         r_root, w_root;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [M_SIZE-1:0]     r_out_mant, w_out_mant;
  logic [EXP_SIZE-1:0]   r_out_exp, w_out_exp;
  logic                  r_out_sign, w_out_sign;
  logic [2:0]            r_out_flags, w_out_flags;
  logic                  r_ready, w_ready;

  logic                  w_accept;
  logic                  w_is_zero;
  logic [M_SIZE-1:0]     w_trunc;
  logic                  w_guard, w_sticky, w_up;
  logic [NB-1:0]         w_low;
  logic [M_SIZE:0]       w_sum;
  logic [EXP_SIZE-1:0]   w_res_exp;

  assign w_accept  = io_bus.start & ~r_start_q & ((r_state == StIdle) | (r_state == StDone));
  assign w_is_zero = (r_flags == 3'b000) && (r_mant == '0);

  // Root holds M_SIZE result bits, one guard bit, then any surplus bits from BPC padding.
  assign w_trunc   = r_root[NB-1 -: M_SIZE];
  assign w_guard   = r_root[NB-M_SIZE-1];
  assign w_low     = r_root << (M_SIZE + 1);
  assign w_sticky  = (|r_rem) | (|w_low);
  assign w_sum     = {1'b0, w_trunc} + {{M_SIZE{1'b0}}, w_up};
  assign w_res_exp = EXP_SIZE'((r_e >>> 1) + BIAS);

  always_comb begin
    case (r_rnd)
      2'b00:   w_up = w_guard & (w_sticky | w_trunc[0]);
      2'b10:   w_up = w_guard | w_sticky;
      default: w_up = 1'b0;
    endcase
  end

  always_comb begin
    logic [RW-1:0] rem_v, rem_t, trial;
    logic [NB-1:0] root_v;
    logic [DW-1:0] rad_v;
    w_state     = r_state;
    w_mant      = r_mant;
    w_e         = r_e;
    w_sign      = r_sign;
    w_flags     = r_flags;
    w_rnd       = r_rnd;
    w_rad       = r_rad;
    w_rem       = r_rem;
    w_root      = r_root;
    w_cnt       = r_cnt;
    w_out_mant  = r_out_mant;
    w_out_exp   = r_out_exp;
    w_out_sign  = r_out_sign;
    w_out_flags = r_out_flags;
    w_ready     = r_ready;
    rem_v       = r_rem;
    rem_t       = '0;
    trial       = '0;
    root_v      = r_root;
    rad_v       = r_rad;

    case (r_state)
      StIdle, StDone: begin
        if (w_accept) begin
          w_mant  = io_bus.in_mantisa;
          w_e     = $signed({1'b0, io_bus.in_exp}) - BIAS;
          w_sign  = io_bus.in_sign;
          w_flags = io_bus.in_flags;
          w_rnd   = io_bus.rnd_mode;
          w_ready = 1'b0;
          w_state = StPrep;
        end
      end
      StPrep: begin
        if (r_flags[0] || (r_sign && !w_is_zero) || w_is_zero || r_flags[1]) begin
          w_state = StDone;
          w_ready = 1'b1;
          if (r_flags[0] || (r_sign && !w_is_zero)) begin
            w_out_mant  = {2'b11, {(M_SIZE-2){1'b0}}};
            w_out_exp   = '1;
            w_out_sign  = 1'b0;
            w_out_flags = {~r_flags[0], 1'b0, 1'b1};
          end else if (w_is_zero) begin
            w_out_mant  = '0;
            w_out_exp   = '0;
            w_out_sign  = r_sign;
            w_out_flags = 3'b000;
          end else begin
            w_out_mant  = {1'b1, {(M_SIZE-1){1'b0}}};
            w_out_exp   = '1;
            w_out_sign  = 1'b0;
            w_out_flags = 3'b000;
          end
        end else if (r_flags == 3'b000) begin
          w_e     = EW'(1) - BIAS;
          w_state = StNorm;
        end else begin
          w_state = StIter;
        end
      end
      StNorm: begin
        w_mant = r_mant << 1;
        w_e    = r_e - EW'(1);
        if (r_mant[M_SIZE-2]) w_state = StIter;
      end
      StIter: begin
        for (int b = 0; b < int'(BPC); b++) begin
          rem_t = {rem_v[RW-3:0], rad_v[DW-1 -: 2]};
          trial = {1'b0, root_v, 2'b01};
          if (rem_t >= trial) begin
            rem_v  = rem_t - trial;
            root_v = {root_v[NB-2:0], 1'b1};
          end else begin
            rem_v  = rem_t;
            root_v = {root_v[NB-2:0], 1'b0};
          end
          rad_v = rad_v << 2;
        end
        w_rem  = rem_v;
        w_root = root_v;
        w_rad  = rad_v;
        if (r_cnt == '0) w_state = StRound;
        else             w_cnt   = r_cnt - CW'(1);
      end
      StRound: begin
        w_state     = StDone;
        w_ready     = 1'b1;
        w_out_sign  = 1'b0;
        w_out_flags = {1'b0, w_guard | w_sticky, 1'b0};
        if (w_sum[M_SIZE]) begin
          w_out_mant = {1'b1, {(M_SIZE-1){1'b0}}};
          w_out_exp  = w_res_exp + EXP_SIZE'(1);
        end else begin
          w_out_mant = w_sum[M_SIZE-1:0];
          w_out_exp  = w_res_exp;
        end
      end
      default: w_state = StIdle;
    endcase

    // An odd exponent is folded into the radicand so the halved exponent stays exact.
    if (w_state == StIter && r_state != StIter) begin
      w_rad  = w_e[0] ? {w_mant, 1'b0, {SH{1'b0}}} : {1'b0, w_mant, {SH{1'b0}}};
      w_e    = w_e[0] ? (w_e - EW'(1)) : w_e;
      w_rem  = '0;
      w_root = '0;
      w_cnt  = CW'(N - 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_start_q   <= 1'b0;
      r_mant      <= '0;
      r_e         <= '0;
      r_sign      <= 1'b0;
      r_flags     <= '0;
      r_rnd       <= '0;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_out_mant  <= '0;
      r_out_exp   <= '0;
      r_out_sign  <= 1'b0;
      r_out_flags <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_start_q   <= io_bus.start;
      r_mant      <= w_mant;
      r_e         <= w_e;
      r_sign      <= w_sign;
      r_flags     <= w_flags;
      r_rnd       <= w_rnd;
      r_rad       <= w_rad;
      r_rem       <= w_rem;
      r_root      <= w_root;
      r_cnt       <= w_cnt;
      r_out_mant  <= w_out_mant;
      r_out_exp   <= w_out_exp;
      r_out_sign  <= w_out_sign;
      r_out_flags <= w_out_flags;
      r_ready     <= w_ready;
    end
  end

  assign io_bus.out_mantisa = r_out_mant;
  assign io_bus.out_exp     = r_out_exp;
  assign io_bus.out_sign    = r_out_sign;
  assign io_bus.out_flags   = r_out_flags;
  assign io_bus.ready       = r_ready;
  assign io_bus.busy        = (r_state != StIdle) && (r_state != StDone);
endmodule
